// File: rtl/vscale_csr_port_arbiter_pkg.sv
// vscale_csr_port_arbiter_pkg
//   Shared constants for the CSR port arbiter: datapath widths, the CSR
//   command encodings the arbiter issues on behalf of the host, the arbiter
//   state encoding and the wait-counter width.
//   Port summary: none (package).
//   Optional feature macro: VSCALE_CSR_ARB_STARVE_GUARD_EN (used by the top
//   and by the wait-counter file).
package vscale_csr_port_arbiter_pkg;

  localparam int CSR_CMD_WIDTH  = 3;
  localparam int CSR_ADDR_WIDTH = 12;
  localparam int XPR_LEN        = 32;
  localparam int HTIF_PCR_WIDTH = 64;

  // Width of the host wait counter; MAX_WAIT must fit in it (1..255).
  localparam int ARB_WAIT_W     = 8;

  // Command encodings the host path drives. Bit 2 of any command marks an
  // active access; IDLE=0, SET=6 and CLEAR=7 only ever come from the core.
  localparam logic [CSR_CMD_WIDTH-1:0] CSR_READ  = 3'd4;
  localparam logic [CSR_CMD_WIDTH-1:0] CSR_WRITE = 3'd5;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,  // ready to accept a host request
    ARB_WAIT = 2'd1,  // host request latched, waiting for the port
    ARB_RESP = 2'd2   // response held until the host takes it
  } arb_state_e;

  function automatic logic [CSR_CMD_WIDTH-1:0] host_csr_cmd(input logic rw);
    return rw ? CSR_WRITE : CSR_READ;
  endfunction

endpackage

// File: rtl/vscale_csr_arb_wait_counter.sv
// vscale_csr_arb_wait_counter
//   Saturating counter that measures how long a latched host request has
//   waited for the CSR port. Only exists when VSCALE_CSR_ARB_STARVE_GUARD_EN
//   is defined; without the guard there is nothing to count, so the module
//   is compiled out entirely.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     clear        : restart counting from zero (host request accepted)
//     en           : count one more waited cycle (saturates at MAX)
//     expired      : count has reached MAX
`ifdef VSCALE_CSR_ARB_STARVE_GUARD_EN
module vscale_csr_arb_wait_counter #(
  parameter int W   = 8,
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == MAX_V);

endmodule
`endif

// File: rtl/vscale_csr_port_arbiter.sv
// vscale_csr_port_arbiter
//   Shares the single CSR-file access port between the core pipeline and the
//   HTIF host PCR channel. Core accesses pass straight through with priority;
//   a host request is latched and issued in the first cycle the core leaves
//   the port idle, then its read data is held as the host response.
//
//   Optional feature: VSCALE_CSR_ARB_STARVE_GUARD_EN. When defined, a wait
//   counter forces a host grant (stalling the core for one cycle) once the
//   request has waited MAX_WAIT cycles. When undefined, no counter exists,
//   core_stall is 0 and MAX_WAIT is ignored.
//
//   Handshakes: both host channels are valid/ready. A request transfers on a
//   clock edge where host_req_valid && host_req_ready; a response transfers
//   on an edge where host_resp_valid && host_resp_ready. Once raised,
//   host_resp_valid and host_resp_data stay steady until that transfer.
//
//   Ports:
//     clk, reset_n                  : clock, asynchronous active-low reset
//     core_cmd/addr/wdata, core_rdata, core_stall : pipeline CSR access
//     host_req_*  / host_req_ready  : HTIF PCR request channel
//     host_resp_* / host_resp_ready : HTIF PCR response channel
//     csr_cmd/addr/wdata, csr_rdata : CSR file access port
//     dbg_state                     : current arbiter state (arb_state_e)
module vscale_csr_port_arbiter
  import vscale_csr_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CSR_CMD_WIDTH-1:0]  core_cmd,
  input  logic [CSR_ADDR_WIDTH-1:0] core_addr,
  input  logic [XPR_LEN-1:0]        core_wdata,
  output logic [XPR_LEN-1:0]        core_rdata,
  output logic                      core_stall,
  input  logic                      host_req_valid,
  input  logic                      host_req_rw,
  input  logic [CSR_ADDR_WIDTH-1:0] host_req_addr,
  input  logic [HTIF_PCR_WIDTH-1:0] host_req_data,
  output logic                      host_req_ready,
  output logic                      host_resp_valid,
  output logic [HTIF_PCR_WIDTH-1:0] host_resp_data,
  input  logic                      host_resp_ready,
  output logic [CSR_CMD_WIDTH-1:0]  csr_cmd,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
  output logic [XPR_LEN-1:0]        csr_wdata,
  input  logic [XPR_LEN-1:0]        csr_rdata,
  output logic [1:0]                dbg_state
);

  arb_state_e                state_q, state_d;
  logic                      req_rw_q, req_rw_d;
  logic [CSR_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [XPR_LEN-1:0]        req_data_q, req_data_d;
  logic [XPR_LEN-1:0]        resp_data_q, resp_data_d;

  logic core_active;
  logic host_accept;
  logic host_grant;
  logic forced_grant;

  assign core_active = core_cmd[2];
  assign host_accept = (state_q == ARB_IDLE) && host_req_valid;

`ifdef VSCALE_CSR_ARB_STARVE_GUARD_EN
  logic wait_expired;

  // Counts WAIT cycles in which the host was denied; cleared on accept so
  // the first WAIT cycle sees zero.
  vscale_csr_arb_wait_counter #(
    .W   (ARB_WAIT_W),
    .MAX (MAX_WAIT)
  ) u_wait_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (host_accept),
    .en      ((state_q == ARB_WAIT) && !host_grant),
    .expired (wait_expired)
  );

  // A forced grant only matters when the core is busy; an idle core grants
  // the host anyway without any stall.
  assign forced_grant = (state_q == ARB_WAIT) && core_active && wait_expired;
`else
  assign forced_grant = 1'b0;
`endif

  // The upper half of the host write data is never written, and MAX_WAIT is
  // meaningless without the guard.
  logic [39:0] unused_bits;
  assign unused_bits = {host_req_data[63:32], 8'(MAX_WAIT)};

  assign host_grant = (state_q == ARB_WAIT) && (!core_active || forced_grant);

  // Next-state and latch updates.
  always_comb begin
    state_d     = state_q;
    req_rw_d    = req_rw_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    resp_data_d = resp_data_q;
    case (state_q)
      ARB_IDLE: begin
        if (host_req_valid) begin
          req_rw_d   = host_req_rw;
          req_addr_d = host_req_addr;
          req_data_d = host_req_data[XPR_LEN-1:0];
          state_d    = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (host_grant) begin
          // Write responses also return the old CSR value read this cycle.
          resp_data_d = csr_rdata;
          state_d     = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (host_resp_ready) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Port mux and handshake outputs.
  always_comb begin
    csr_cmd    = core_cmd;
    csr_addr   = core_addr;
    csr_wdata  = core_wdata;
    core_rdata = csr_rdata;
    if (host_grant) begin
      csr_cmd    = host_csr_cmd(req_rw_q);
      csr_addr   = req_addr_q;
      csr_wdata  = req_data_q;
      core_rdata = '0;
    end
  end

  assign core_stall      = forced_grant;
  assign host_req_ready  = (state_q == ARB_IDLE);
  assign host_resp_valid = (state_q == ARB_RESP);
  assign host_resp_data  = {32'b0, resp_data_q};
  assign dbg_state       = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      req_rw_q    <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      req_rw_q    <= req_rw_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      resp_data_q <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_vscale_csr_port_arbiter.sv
// tb_vscale_csr_port_arbiter
//   Bench for vscale_csr_port_arbiter. A transaction-level model tracks the
//   one outstanding host request (pending / how long it has waited / the
//   response owed) and a compare process checks every DUT output against it
//   on each falling edge. Directed sequences pin the model with literal
//   expectations, then a randomized phase exercises the mix.
//   Honors VSCALE_CSR_ARB_STARVE_GUARD_EN the same way the design does.
module tb_vscale_csr_port_arbiter;

  localparam int MW = 4;
`ifdef VSCALE_CSR_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  core_cmd = '0;
  logic [11:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        host_req_valid = 1'b0;
  logic        host_req_rw = 1'b0;
  logic [11:0] host_req_addr = '0;
  logic [63:0] host_req_data = '0;
  logic        host_req_ready;
  logic        host_resp_valid;
  logic [63:0] host_resp_data;
  logic        host_resp_ready = 1'b0;
  logic [2:0]  csr_cmd;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata = '0;
  logic [1:0]  dbg_state;

  vscale_csr_port_arbiter #(.MAX_WAIT(MW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .core_cmd        (core_cmd),
    .core_addr       (core_addr),
    .core_wdata      (core_wdata),
    .core_rdata      (core_rdata),
    .core_stall      (core_stall),
    .host_req_valid  (host_req_valid),
    .host_req_rw     (host_req_rw),
    .host_req_addr   (host_req_addr),
    .host_req_data   (host_req_data),
    .host_req_ready  (host_req_ready),
    .host_resp_valid (host_resp_valid),
    .host_resp_data  (host_resp_data),
    .host_resp_ready (host_resp_ready),
    .csr_cmd         (csr_cmd),
    .csr_addr        (csr_addr),
    .csr_wdata       (csr_wdata),
    .csr_rdata       (csr_rdata),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One host transaction at a time: either pending (waiting for the port),
  // owed as a response, or nothing outstanding.
  bit          m_pend;
  bit          m_rw;
  logic [11:0] m_addr;
  logic [31:0] m_data;
  int          m_waited;   // WAIT cycles already spent before this one
  bit          m_resp;
  logic [63:0] m_resp_val;
  bit          m_g;

  function automatic bit m_granted();
    return m_pend && (!core_cmd[2] || (GUARD && (m_waited >= MW)));
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = 1'b0; m_rw = 1'b0; m_addr = '0; m_data = '0;
      m_waited = 0; m_resp = 1'b0; m_resp_val = '0;
    end else begin
      m_g = m_granted();
      if (m_resp) begin
        if (host_resp_ready) m_resp = 1'b0;
      end else if (m_pend) begin
        if (m_g) begin
          m_resp_val = {32'b0, csr_rdata};
          m_resp = 1'b1;
          m_pend = 1'b0;
        end else begin
          m_waited++;
        end
      end else if (host_req_valid) begin
        m_pend = 1'b1;
        m_rw = host_req_rw;
        m_addr = host_req_addr;
        m_data = host_req_data[31:0];
        m_waited = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      bit g;
      g = m_granted();
      chk("csr_cmd",   64'(csr_cmd),    g ? (m_rw ? 64'd5 : 64'd4) : 64'(core_cmd));
      chk("csr_addr",  64'(csr_addr),   g ? 64'(m_addr) : 64'(core_addr));
      chk("csr_wdata", 64'(csr_wdata),  g ? 64'(m_data) : 64'(core_wdata));
      chk("core_rdata", 64'(core_rdata), g ? 64'd0 : 64'(csr_rdata));
      chk("core_stall", 64'(core_stall), 64'(g && core_cmd[2]));
      chk("req_ready", 64'(host_req_ready), 64'(!m_pend && !m_resp));
      chk("resp_valid", 64'(host_resp_valid), 64'(m_resp));
      chk("resp_data", host_resp_data, m_resp_val);
      chk("dbg_state", 64'(dbg_state), m_pend ? 64'd1 : (m_resp ? 64'd2 : 64'd0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic host_req(input bit rw, input logic [11:0] addr, input logic [63:0] data);
    host_req_valid = 1'b1;
    host_req_rw    = rw;
    host_req_addr  = addr;
    host_req_data  = data;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] held;
    int stalls;
    int first_stall;

    #2 reset_n = 1'b0;
    #1;
    chk("rst_req_ready", 64'(host_req_ready), 64'd1);
    chk("rst_resp_valid", 64'(host_resp_valid), 64'd0);
    chk("rst_resp_data", host_resp_data, 64'd0);
    chk("rst_core_stall", 64'(core_stall), 64'd0);
    core_cmd = 3'd6; core_addr = 12'h305; core_wdata = 32'h1234;
    #1;
    chk("rst_passthru_cmd", 64'(csr_cmd), 64'd6);
    chk("rst_passthru_addr", 64'(csr_addr), 64'h305);
    chk_en = 1'b1;
    cyc(); cyc();
    reset_n = 1'b1;
    core_cmd = 3'd0;
    cyc();

    // Idle core, host read of to_host.
    host_req(1'b0, 12'h780, 64'h0);
    csr_rdata = 32'hDEADBEEF;
    cyc();                      // accept edge N
    host_req_valid = 1'b0;
    chk("t1_req_ready_after_accept", 64'(host_req_ready), 64'd0);
    chk("t1_resp_valid_early", 64'(host_resp_valid), 64'd0);
    #2;
    chk("t1_csr_cmd", 64'(csr_cmd), 64'd4);
    chk("t1_csr_addr", 64'(csr_addr), 64'h780);
    cyc();                      // edge N+1
    chk("t1_resp_valid", 64'(host_resp_valid), 64'd1);
    chk("t1_resp_data", host_resp_data, 64'h0000_0000_DEAD_BEEF);
    host_resp_ready = 1'b1;
    cyc();
    host_resp_ready = 1'b0;
    chk("t1_idle_again", 64'(host_req_ready), 64'd1);

    // Core holds the port with SET for 3 cycles; host write goes in after.
    host_req(1'b1, 12'h341, 64'hFFFF_FFFF_0000_0100);
    cyc();
    host_req_valid = 1'b0;
    core_cmd = 3'd6;
    for (int i = 0; i < 3; i++) begin
      core_addr = 12'($urandom);
      core_wdata = $urandom;
      csr_rdata = $urandom;
      #2;
      chk("t2_core_cmd_pass", 64'(csr_cmd), 64'd6);
      chk("t2_core_rdata", 64'(core_rdata), 64'(csr_rdata));
      cyc();
    end
    core_cmd = 3'd0;
    csr_rdata = 32'h0000_0ABC;
    #2;
    chk("t2_host_cmd", 64'(csr_cmd), 64'd5);
    chk("t2_host_addr", 64'(csr_addr), 64'h341);
    chk("t2_host_wdata", 64'(csr_wdata), 64'h100);
    cyc();
    chk("t2_resp_data", host_resp_data, 64'h0ABC);

    // Response backpressure for 6 cycles.
    held = host_resp_data;
    for (int i = 0; i < 6; i++) begin
      csr_rdata = $urandom;
      core_cmd = (i % 2 == 0) ? 3'd4 : 3'd0;
      cyc();
      chk("t5_resp_valid_held", 64'(host_resp_valid), 64'd1);
      chk("t5_resp_data_held", host_resp_data, held);
      chk("t5_req_ready_low", 64'(host_req_ready), 64'd0);
    end
    core_cmd = 3'd0;
    host_resp_ready = 1'b1;
    cyc();
    host_resp_ready = 1'b0;
    chk("t5_req_ready_back", 64'(host_req_ready), 64'd1);
    chk("t5_resp_valid_drop", 64'(host_resp_valid), 64'd0);

`ifdef VSCALE_CSR_ARB_STARVE_GUARD_EN
    // Starvation: core READ held; exactly one forced grant, 5th WAIT cycle.
    host_req(1'b0, 12'h342, 64'h0);
    cyc();
    host_req_valid = 1'b0;
    core_cmd = 3'd4;
    stalls = 0;
    first_stall = 0;
    for (int k = 1; k <= 20; k++) begin
      csr_rdata = $urandom;
      #2;
      if (core_stall) begin
        stalls++;
        if (first_stall == 0) first_stall = k;
      end
      cyc();
    end
    chk("t3_stall_count", 64'(stalls), 64'd1);
    chk("t3_first_stall_cycle", 64'(first_stall), 64'(MW + 1));
    host_resp_ready = 1'b1;
    core_cmd = 3'd0;
    cyc();
    host_resp_ready = 1'b0;
`else
    // No guard: core busy for 300 cycles, host granted in cycle 301.
    host_req(1'b1, 12'h780, 64'h5A5A);
    cyc();
    host_req_valid = 1'b0;
    core_cmd = 3'd7;
    stalls = 0;
    for (int k = 1; k <= 300; k++) begin
      csr_rdata = $urandom;
      #2;
      if (core_stall) stalls++;
      cyc();
    end
    chk("t6_no_stall", 64'(stalls), 64'd0);
    chk("t6_no_resp_yet", 64'(host_resp_valid), 64'd0);
    core_cmd = 3'd0;
    #2;
    chk("t6_grant_cmd", 64'(csr_cmd), 64'd5);
    chk("t6_grant_wdata", 64'(csr_wdata), 64'h5A5A);
    cyc();
    chk("t6_resp_valid", 64'(host_resp_valid), 64'd1);
    host_resp_ready = 1'b1;
    cyc();
    host_resp_ready = 1'b0;
`endif

    // Reset mid-WAIT: pending write must be dropped.
    core_cmd = 3'd5;
    host_req(1'b1, 12'h300, 64'h8);
    cyc();
    host_req_valid = 1'b0;
    cyc();
    #2 reset_n = 1'b0;
    #1;
    chk("t4_wait_rst_req_ready", 64'(host_req_ready), 64'd1);
    chk("t4_wait_rst_resp_valid", 64'(host_resp_valid), 64'd0);
    chk("t4_wait_rst_state", 64'(dbg_state), 64'd0);
    cyc();
    reset_n = 1'b1;
    core_cmd = 3'd0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("t4_no_write_after", 64'(csr_cmd), 64'd0);
      cyc();
    end

    // Reset mid-RESP: resp_valid falls without a clock.
    host_req(1'b0, 12'hB00, 64'h0);
    csr_rdata = 32'hCAFE_F00D;
    cyc();
    host_req_valid = 1'b0;
    cyc();
    chk("t4_resp_before_rst", 64'(host_resp_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t4_resp_rst_valid", 64'(host_resp_valid), 64'd0);
    chk("t4_resp_rst_data", host_resp_data, 64'd0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 4) core_cmd = 3'd0;
      else core_cmd = 3'($urandom_range(4, 7));
      core_addr       = 12'($urandom);
      core_wdata      = $urandom;
      csr_rdata       = $urandom;
      host_req_valid  = ($urandom_range(0, 1) == 1);
      host_req_rw     = ($urandom_range(0, 1) == 1);
      host_req_addr   = 12'($urandom);
      host_req_data   = {$urandom, $urandom};
      host_resp_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
